mem_master: RTL and testbench
=============================

MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 Parameter: MEM_BYTES, default 1024, byte capacity of attached memory; legal addresses 0..MEM_BYTES-1.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  requester presents a request.
REQ-005 req_ready  output  1  block can accept a request this cycle.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_byte  input  1  1 = byte access, 0 = word access.
REQ-008 req_signed  input  1  byte loads: 1 = sign-extend, 0 = zero-extend; ignored otherwise.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data; byte stores use [7:0].
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_ready  input  1  requester accepts the response.
REQ-013 resp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 resp_err  output  1  request rejected (misaligned or out of range); memory untouched.
REQ-015 A  output  32  memory byte address, always word-aligned when MemWrite=1.
REQ-016 WD  output  32  memory write data, big-endian (WD[31:24] stored at A).
REQ-017 MemWrite  output  1  memory write strobe; memory writes on the next rising edge.
REQ-018 RD  input  32  combinational memory read data for A, big-endian (RD[31:24] = byte at A).

Function
REQ-019 FSM states: IDLE, READ, WRITE, RESP; one request outstanding at most.
REQ-020 req_ready = 1 only in IDLE with reset low; a handshake is req_valid & req_ready; all request fields are latched at that edge.
REQ-021 Error check at accept: word access with req_addr[1:0] != 0, or req_addr > MEM_BYTES-1 (byte) or > MEM_BYTES-4 (word) -> resp_err=1, IDLE -> RESP, no memory cycle.
REQ-022 Legal word store: IDLE -> WRITE -> RESP; WRITE drives A=addr, WD=wdata, MemWrite=1 for exactly one cycle.
REQ-023 Legal load (word or byte): IDLE -> READ -> RESP; READ drives A={addr[31:2],2'b00}, MemWrite=0; RD registered at end of READ.
REQ-024 Byte select: offset addr[1:0]=0,1,2,3 selects RD[31:24],[23:16],[15:8],[7:0]; extended to 32 bits per req_signed.
REQ-025 Byte store (read-modify-write): IDLE -> READ -> WRITE -> RESP; WRITE writes the READ word with the selected byte lane replaced by wdata[7:0], other lanes unchanged.
REQ-026 Latency from accept edge N: error resp_valid at N+1; word store/any load at N+2; byte store at N+3.
REQ-027 RESP holds resp_valid=1 and stable resp_rdata/resp_err until resp_valid & resp_ready; then -> IDLE, resp_valid=0 next cycle.
REQ-028 req_ready=0 in RESP; a new request is accepted no earlier than the cycle after response handshake.
REQ-029 Outside READ/WRITE: A=0, WD=0, MemWrite=0.
REQ-030 MemWrite asserted only in WRITE and never more than one cycle per request.

Reset
REQ-031 reset high at a rising edge -> state IDLE; resp_valid=0, resp_err=0, resp_rdata=0, latched request cleared.
REQ-032 While reset high: req_ready=0, MemWrite=0, A=0, WD=0 (combinationally gated), regardless of state.
REQ-033 Reset mid-operation aborts the request: no response is produced; a byte store aborted in READ causes no write.
REQ-034 First request is accepted in the first cycle after reset deasserts.

Verification
REQ-035 Word store addr=0x10, data=0xDEADBEEF, then word load 0x10 -> MemWrite one cycle with A=0x10; load resp_rdata=0xDEADBEEF at N+2, resp_err=0.
REQ-036 Memory 0x20..0x23 = 11 22 83 44; byte load 0x22 signed -> 0xFFFFFF83; unsigned -> 0x00000083.
REQ-037 Byte store addr=0x21, data=0xAB over word 0x11228344 -> one write at N+2 to A=0x20 with WD=0x11AB8344; resp_valid at N+3.
REQ-038 Word load addr=0x13 and word load addr=0x3FE (MEM_BYTES=1024) -> resp_err=1 at N+1, resp_rdata=0, MemWrite never asserted.
REQ-039 resp_ready held 0 for 5 cycles -> resp_valid/resp_rdata stable, req_ready=0, concurrent req_valid not accepted.
REQ-040 Reset asserted during READ of a byte store to 0x21 -> no MemWrite, no resp_valid, word 0x20 unchanged, req_ready=1 the cycle after reset deasserts.

Source files
------------

// File: rtl/mem_master.sv
// Request/response front end for a single-port big-endian word memory.
// Supports word and byte loads/stores; byte stores use a read-modify-write cycle.
module mem_master #(
   parameter int unsigned MEM_BYTES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic        req_byte,
   input  logic        req_signed,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] A,
   output logic [31:0] WD,
   output logic        MemWrite,
   input  logic [31:0] RD
);

   localparam logic [31:0] LAST_BYTE = 32'(MEM_BYTES - 1);
   localparam logic [31:0] LAST_WORD = 32'(MEM_BYTES - 4);

   typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

   state_t      state_q;
   logic        write_q;
   logic        byte_q;
   logic        signed_q;
   logic [1:0]  off_q;
   logic [7:0]  wbyte_q;
   logic [31:0] a_q;
   logic [31:0] wd_q;
   logic        mem_write_q;
   logic        resp_valid_q;
   logic        resp_err_q;
   logic [31:0] resp_rdata_q;

   logic        req_err_d;
   logic [7:0]  rd_lane [4];
   logic [7:0]  sel_byte_d;
   logic [31:0] load_data_d;
   logic [31:0] merge_word_d;

   // Lane gi is the byte at offset gi of the word (big-endian: offset 0 is the MSB).
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign rd_lane[gi] = RD[31-8*gi -: 8];
         assign merge_word_d[31-8*gi -: 8] = (off_q == 2'(gi)) ? wbyte_q : RD[31-8*gi -: 8];
      end
   endgenerate

   always_comb begin
      req_err_d = 1'b0;
      if (req_byte) begin
         req_err_d = (req_addr > LAST_BYTE);
      end else begin
         req_err_d = (req_addr[1:0] != 2'b00) || (req_addr > LAST_WORD);
      end
   end

   always_comb begin
      sel_byte_d  = rd_lane[off_q];
      load_data_d = RD;
      if (byte_q) begin
         load_data_d = signed_q ? {{24{sel_byte_d[7]}}, sel_byte_d} : {24'd0, sel_byte_d};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         write_q      <= 1'b0;
         byte_q       <= 1'b0;
         signed_q     <= 1'b0;
         off_q        <= 2'b00;
         wbyte_q      <= 8'd0;
         a_q          <= 32'd0;
         wd_q         <= 32'd0;
         mem_write_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= 32'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  write_q  <= req_write;
                  byte_q   <= req_byte;
                  signed_q <= req_signed;
                  off_q    <= req_addr[1:0];
                  wbyte_q  <= req_wdata[7:0];
                  if (req_err_d) begin
                     state_q      <= RESP;
                     resp_valid_q <= 1'b1;
                     resp_err_q   <= 1'b1;
                     resp_rdata_q <= 32'd0;
                  end else if (req_write && !req_byte) begin
                     state_q     <= WRITE;
                     a_q         <= req_addr;
                     wd_q        <= req_wdata;
                     mem_write_q <= 1'b1;
                  end else begin
                     state_q <= READ;
                     a_q     <= {req_addr[31:2], 2'b00};
                  end
               end
            end
            READ: begin
               if (write_q) begin
                  // Byte store: splice the new byte into the word just read.
                  state_q     <= WRITE;
                  wd_q        <= merge_word_d;
                  mem_write_q <= 1'b1;
               end else begin
                  state_q      <= RESP;
                  a_q          <= 32'd0;
                  resp_valid_q <= 1'b1;
                  resp_err_q   <= 1'b0;
                  resp_rdata_q <= load_data_d;
               end
            end
            WRITE: begin
               state_q      <= RESP;
               a_q          <= 32'd0;
               wd_q         <= 32'd0;
               mem_write_q  <= 1'b0;
               resp_valid_q <= 1'b1;
               resp_err_q   <= 1'b0;
               resp_rdata_q <= 32'd0;
            end
            RESP: begin
               if (resp_ready) begin
                  state_q      <= IDLE;
                  resp_valid_q <= 1'b0;
                  resp_err_q   <= 1'b0;
                  resp_rdata_q <= 32'd0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Memory-side outputs are forced idle while reset is high, whatever the state.
   assign req_ready  = (state_q == IDLE) && !reset;
   assign A          = reset ? 32'd0 : a_q;
   assign WD         = reset ? 32'd0 : wd_q;
   assign MemWrite   = mem_write_q && !reset;
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master: vector table plus stall and mid-operation reset sequences.
// A small big-endian byte memory model answers RD and absorbs MemWrite.
module tb_mem_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_write, req_byte, req_signed;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata, A, WD, RD;
   logic        MemWrite;

   logic [7:0]  mem [1024];
   int          n_pass = 0;
   int          n_total = 0;
   int          wr_events = 0;

   always #5 clk = ~clk;

   mem_master #(.MEM_BYTES(1024)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_byte(req_byte), .req_signed(req_signed), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err),
      .A(A), .WD(WD), .MemWrite(MemWrite), .RD(RD)
   );

   always_comb begin
      RD = {mem[A[9:0]], mem[10'(A[9:0] + 10'd1)], mem[10'(A[9:0] + 10'd2)], mem[10'(A[9:0] + 10'd3)]};
   end

   always @(posedge clk) begin
      if (MemWrite) begin
         mem[A[9:0]]                <= WD[31:24];
         mem[10'(A[9:0] + 10'd1)]   <= WD[23:16];
         mem[10'(A[9:0] + 10'd2)]   <= WD[15:8];
         mem[10'(A[9:0] + 10'd3)]   <= WD[7:0];
         wr_events                  <= wr_events + 1;
      end
   end

   typedef struct {
      logic        wr;
      logic        is_byte;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rdata;
      int          lat;
      int          wcnt;
      logic [31:0] wa;
      logic [31:0] wd;
      int          wcyc;
   } vec_t;

   vec_t vecs [20];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int cyc, wcnt, wcyc;
      bit got;
      logic [31:0] wa, wd;
      wcnt = 0; wcyc = 0; got = 0; wa = 0; wd = 0;
      req_write = v.wr; req_byte = v.is_byte; req_signed = v.sgn;
      req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
      chk("req_ready_before_accept", {31'd0, req_ready}, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      cyc = 1;
      while (cyc <= 8 && !got) begin
         if (MemWrite) begin
            wcnt++; wa = A; wd = WD; wcyc = cyc;
         end
         if (resp_valid) got = 1;
         else begin
            @(posedge clk); #1;
            cyc++;
         end
      end
      chk("latency", got ? 32'(cyc) : 32'd0, 32'(v.lat));
      chk("resp_err", {31'd0, resp_err}, {31'd0, v.err});
      chk("resp_rdata", resp_rdata, v.rdata);
      chk("mem_idle_in_resp", {MemWrite, A[30:0] | WD[30:0] | {30'd0, A[31] | WD[31]}}, 32'd0);
      chk("write_count", 32'(wcnt), 32'(v.wcnt));
      if (v.wcnt == 1) begin
         chk("write_addr", wa, v.wa);
         chk("write_data", wd, v.wd);
         chk("write_cycle", 32'(wcyc), 32'(v.wcyc));
      end
      @(posedge clk); #1;
      chk("resp_valid_drops", {31'd0, resp_valid}, 32'd0);
      chk("req_ready_after_resp", {31'd0, req_ready}, 32'd1);
      $display("vec %0d: wr=%0b byte=%0b sgn=%0b addr=0x%08h lat=%0d err=%0b rdata=0x%08h writes=%0d",
               idx, v.wr, v.is_byte, v.sgn, v.addr, cyc, resp_err, resp_rdata, wcnt);
   endtask

   initial begin
      int wr_base;
      logic [31:0] held;

      //          wr  byte sgn  addr          wdata          err  rdata          lat wcnt wa            wd             wcyc
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0,         2, 1, 32'h10,  32'hDEADBEEF, 1};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF,  2, 0, 32'h0,   32'h0,        0};
      vecs[2]  = '{1'b0, 1'b1, 1'b1, 32'h22,  32'h0,        1'b0, 32'hFFFFFF83,  2, 0, 32'h0,   32'h0,        0};
      vecs[3]  = '{1'b0, 1'b1, 1'b0, 32'h22,  32'h0,        1'b0, 32'h00000083,  2, 0, 32'h0,   32'h0,        0};
      vecs[4]  = '{1'b1, 1'b1, 1'b0, 32'h21,  32'h000000AB, 1'b0, 32'h0,         3, 1, 32'h20,  32'h11AB8344, 2};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 32'h20,  32'h0,        1'b0, 32'h11AB8344,  2, 0, 32'h0,   32'h0,        0};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h13,  32'h0,        1'b1, 32'h0,         1, 0, 32'h0,   32'h0,        0};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h3FE, 32'h0,        1'b1, 32'h0,         1, 0, 32'h0,   32'h0,        0};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 32'h3FF, 32'h0,        1'b0, 32'h0000005A,  2, 0, 32'h0,   32'h0,        0};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 32'h400, 32'h0,        1'b1, 32'h0,         1, 0, 32'h0,   32'h0,        0};
      vecs[10] = '{1'b1, 1'b0, 1'b0, 32'h3FC, 32'h01020304, 1'b0, 32'h0,         2, 1, 32'h3FC, 32'h01020304, 1};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 32'h3FC, 32'h0,        1'b0, 32'h01020304,  2, 0, 32'h0,   32'h0,        0};
      vecs[12] = '{1'b0, 1'b1, 1'b1, 32'h20,  32'h0,        1'b0, 32'h00000011,  2, 0, 32'h0,   32'h0,        0};
      vecs[13] = '{1'b1, 1'b1, 1'b0, 32'h23,  32'h123456FF, 1'b0, 32'h0,         3, 1, 32'h20,  32'h11AB83FF, 2};
      vecs[14] = '{1'b0, 1'b1, 1'b1, 32'h23,  32'h0,        1'b0, 32'hFFFFFFFF,  2, 0, 32'h0,   32'h0,        0};
      vecs[15] = '{1'b1, 1'b0, 1'b0, 32'h12,  32'h55555555, 1'b1, 32'h0,         1, 0, 32'h0,   32'h0,        0};
      vecs[16] = '{1'b1, 1'b1, 1'b0, 32'h400, 32'h000000EE, 1'b1, 32'h0,         1, 0, 32'h0,   32'h0,        0};
      vecs[17] = '{1'b0, 1'b0, 1'b0, 32'h3FD, 32'h0,        1'b1, 32'h0,         1, 0, 32'h0,   32'h0,        0};
      vecs[18] = '{1'b0, 1'b1, 1'b1, 32'h3FC, 32'h0,        1'b0, 32'h00000001,  2, 0, 32'h0,   32'h0,        0};
      vecs[19] = '{1'b0, 1'b0, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF,  2, 0, 32'h0,   32'h0,        0};

      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      mem[32'h20] = 8'h11; mem[32'h21] = 8'h22; mem[32'h22] = 8'h83; mem[32'h23] = 8'h44;
      mem[32'h3FF] = 8'h5A;

      reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0; req_signed = 1'b0;
      req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_A", A, 32'd0);
      chk("rst_WD", WD, 32'd0);
      chk("rst_MemWrite", {31'd0, MemWrite}, 32'd0);
      reset = 1'b0;
      #1;
      chk("req_ready_after_reset", {31'd0, req_ready}, 32'd1);
      $display("reset: req_ready=%0b resp_valid=%0b", req_ready, resp_valid);

      for (int i = 0; i < 20; i++) run_vec(i, vecs[i]);

      // Response back-pressure: hold resp_ready low with a competing request pending.
      wr_base = wr_events;
      resp_ready = 1'b0;
      req_write = 1'b0; req_byte = 1'b0; req_signed = 1'b0; req_addr = 32'h10; req_valid = 1'b1;
      @(posedge clk); #1;
      req_write = 1'b1; req_wdata = 32'h0; req_addr = 32'h10;
      @(posedge clk); #1;
      chk("stall_resp_valid_arrives", {31'd0, resp_valid}, 32'd1);
      held = 32'hDEADBEEF;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         chk("stall_resp_valid", {31'd0, resp_valid}, 32'd1);
         chk("stall_resp_rdata", resp_rdata, held);
         chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
      end
      req_valid = 1'b0; resp_ready = 1'b1;
      @(posedge clk); #1;
      chk("stall_release_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("stall_no_writes", 32'(wr_events - wr_base), 32'd0);
      $display("stall: held rdata 0x%08h for 5 cycles, writes=%0d", held, wr_events - wr_base);
      run_vec(20, vecs[19]);

      // Reset during the READ phase of a byte store.
      wr_base = wr_events;
      req_write = 1'b1; req_byte = 1'b1; req_signed = 1'b0; req_addr = 32'h21; req_wdata = 32'h77;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("abort_read_A", A, 32'h20);
      reset = 1'b1;
      #1;
      chk("abort_gated_A", A, 32'd0);
      chk("abort_gated_req_ready", {31'd0, req_ready}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
      for (int k = 0; k < 4; k++) begin
         chk("abort_no_resp", {31'd0, resp_valid}, 32'd0);
         @(posedge clk); #1;
      end
      chk("abort_no_write", 32'(wr_events - wr_base), 32'd0);
      chk("abort_mem_21", {24'd0, mem[32'h21]}, 32'h000000AB);
      $display("abort: writes=%0d mem[0x21]=0x%02h", wr_events - wr_base, mem[32'h21]);
      vecs[5].rdata = 32'h11AB83FF;
      run_vec(21, vecs[5]);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
